// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: blank code, glyph table, index width.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low a..g in bits 7:1, dp bit (bit 0) held off.
    localparam logic [7:0] SEG_GLYPH [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    function automatic int seg_ww(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bus between the debug register block (master) and the display scanner (slave).
// The blink lane exists only when SEG_BLINK_EN is defined.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 8
) ();
    import seg_pkg::*;

    localparam int WW = seg_ww(DIGITS);

    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic                load;
    logic                blank_lz;
`ifdef SEG_BLINK_EN
    logic [DIGITS-1:0]   blink;
`endif
    logic [WW-1:0]       which;
    logic [7:0]          code;

`ifdef SEG_BLINK_EN
    modport master (output data, dp, load, blank_lz, blink, input which, code);
    modport slave  (input data, dp, load, blank_lz, blink, output which, code);
`else
    modport master (output data, dp, load, blank_lz, input which, code);
    modport slave  (input data, dp, load, blank_lz, output which, code);
`endif

endinterface

// File: rtl/seg_glyph_rom.sv
// Hex nibble to active-low a..g segment pattern.
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_GLYPH[nib][7:1];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with shadow register, blank gap and leading-zero
// suppression. Define SEG_BLINK_EN to add per-digit blink driven by a frame counter.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 16384,
    parameter int BLANK_CYC    = 64,
    parameter int BLINK_FRAMES = 64
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int WW = seg_ww(DIGITS);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
        $error("seg_scan_ctrl: DIGITS out of range");
    end
    if (SCAN_DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_scan
        $error("seg_scan_ctrl: bad SCAN_DIV/BLANK_CYC");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("seg_scan_ctrl: BLINK_FRAMES must be at least 1");
    end

    logic [CW-1:0]       cnt, cnt_n;
    logic [WW-1:0]       which, which_n;
    logic [4*DIGITS-1:0] shadow_data;
    logic [DIGITS-1:0]   shadow_dp;
    logic [7:0]          code, code_n;
    logic                tick, frame_end;
    logic [3:0]          nib_n;
    logic [6:0]          seg_n;
    logic [DIGITS-1:0]   lz_run;
    logic                lz_blank;
    logic                blink_off;

    assign tick      = (cnt == CW'(SCAN_DIV - 1));
    assign frame_end = tick && (which == WW'(DIGITS - 1));
    assign cnt_n     = tick ? '0 : cnt + 1'b1;
    assign which_n   = !tick ? which : (frame_end ? '0 : which + 1'b1);

    // Digit 0 sits in the top nibble of the shadow.
    assign nib_n = shadow_data[4*(DIGITS-1-int'(which_n)) +: 4];

    seg_glyph_rom u_rom (
        .nib (nib_n),
        .seg (seg_n)
    );

    // lz_run[i] is set when nibbles 0..i are all zero.
    always_comb begin
        logic run;
        run    = 1'b1;
        lz_run = '0;
        for (int i = 0; i < DIGITS; i++) begin
            run       = run & (shadow_data[4*(DIGITS-1-i) +: 4] == 4'h0);
            lz_run[i] = run;
        end
    end

    assign lz_blank = bus.blank_lz && lz_run[which_n] && (which_n != WW'(DIGITS - 1));

`ifdef SEG_BLINK_EN
    logic [FW-1:0] fcnt;
    logic          phase_on, phase_n;
    logic          fcnt_max;

    assign fcnt_max  = (fcnt == FW'(BLINK_FRAMES - 1));
    assign phase_n   = (frame_end && fcnt_max) ? !phase_on : phase_on;
    assign blink_off = !phase_n && bus.blink[which_n];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt     <= '0;
            phase_on <= 1'b1;
        end else begin
            phase_on <= phase_n;
            if (frame_end) fcnt <= fcnt_max ? '0 : fcnt + 1'b1;
        end
    end
`else
    assign blink_off = 1'b0;
`endif

    always_comb begin
        code_n = SEG_OFF;
        if (int'(cnt_n) < BLANK_CYC || blink_off) code_n = SEG_OFF;
        else if (lz_blank)                        code_n = {7'h7F, ~shadow_dp[which_n]};
        else                                      code_n = {seg_n, ~shadow_dp[which_n]};
    end

    // Output stage: which and code are registered together from next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            which       <= '0;
            code        <= SEG_OFF;
            shadow_data <= '0;
            shadow_dp   <= '0;
        end else begin
            cnt   <= cnt_n;
            which <= which_n;
            code  <= code_n;
            if (bus.load) begin
                shadow_data <= bus.data;
                shadow_dp   <= bus.dp;
            end
        end
    end

    assign bus.which = which;
    assign bus.code  = code;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed seven-segment display scanner for the board's debug display. It latches a DIGITS-nibble hex value, with per-digit decimal points, into a shadow register on a load strobe. It then time-multiplexes the digits at a programmable refresh rate, with an anti-ghosting blank gap, optional leading-zero suppression and optional per-digit blink. It sits between the CPU debug/bus-visible registers and the board's digit-select and segment pins.

## Interface
- DIGITS, 8: number of digits, 1..16.
- SCAN_DIV, 16384: clk cycles per digit slot, ≥2.
- BLANK_CYC, 64: cycles at the start of each slot with all segments off, 0 ≤ BLANK_CYC < SCAN_DIV.
- BLINK_FRAMES, 64: full scan frames per blink half-period. Used only with SEG_BLINK_EN.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- data  in  4*DIGITS  hex value. Digit i shows data[4*(DIGITS-i)-1 -: 4], so digit 0 is the most significant.
- dp  in  DIGITS  decimal point enables; dp[i] belongs to digit i.
- load  in  1  single-cycle strobe that captures data and dp into the shadow.
- blank_lz  in  1  level; enables leading-zero suppression.
- blink  in  DIGITS  per-digit blink enable. Present only with SEG_BLINK_EN.
- which  out  WW  active digit index, where WW = DIGITS>1 ? $clog2(DIGITS) : 1.
- code  out  8  active-low segments: code[7:1] = a..g, code[0] = dp.

## Operation
- **Shadow register:** on a clk edge with load=1, shadow_data←data and shadow_dp←dp. The display never reads data or dp directly.
- **Prescaler:** cnt runs 0..SCAN_DIV-1 and wraps. tick = (cnt==SCAN_DIV-1).
- **Digit index:** on tick, which←(which==DIGITS-1) ? 0 : which+1. A frame ends on each wrap from DIGITS-1 to 0.
- **Registered output:** code is updated every edge from the next-state values (cnt_n, which_n, shadow):
  - cnt_n < BLANK_CYC → 8'hFF.
  - digit blanked → segments off, code[7:1]=7'h7F, code[0]=~shadow_dp[which_n].
  - otherwise → glyph(nibble[which_n]) with code[0]=~shadow_dp[which_n].
- **Glyphs (active low, dp bit = 1):** 0:03, 1:9F, 2:25, 3:0D, 4:99, 5:49, 6:41, 7:1F, 8:01, 9:09, A:11, B:C1, C:63, D:85, E:61, F:71.
- **Leading-zero suppression:** digit i is blanked when blank_lz=1, shadow nibbles 0..i are all zero, and i≠DIGITS-1. The least significant digit always shows.
- A change on blank_lz acts immediately, with no latch.

## Timing
- Reset values: cnt=0, which=0, code=8'hFF, shadow_data=0, shadow_dp=0, blink phase=on, frame counter=0. Reset clears asynchronously.
- Latency: load sampled at edge N → code reflects the new value from edge N+1 if the current slot is in its glyph phase.
- Each slot lasts exactly SCAN_DIV cycles, of which BLANK_CYC cycles are 8'hFF.
- which and code change on the same edge.
- load during a blank gap or on a tick edge: the shadow still updates, and the glyph appears at the first non-blank cycle.
- Reset mid-slot: which→0 and code→8'hFF immediately. Scanning restarts from digit 0 with a full slot.
- DIGITS=1: which is constantly 0, and every tick ends a frame.

## Configuration
- Macro SEG_BLINK_EN.
- Defined:
  - The blink port and a frame counter 0..BLINK_FRAMES-1 exist.
  - On a frame end with the counter at its maximum, phase toggles.
  - In the off phase, any digit with blink[i]=1 outputs 8'hFF, dp included.
- Undefined: no blink port and no counter. Behaviour is identical to blink=0.

## Structure
- Package seg_pkg:
  - SEG_OFF = 8'hFF.
  - The 16-entry glyph constant array.
  - The width helper for WW.
- Sub-module seg_glyph_rom: combinational mapping of 4-bit nibble → 7 segment bits. Instantiated once and fed the next-state nibble.

## Test plan
Bench settings: DIGITS=8, SCAN_DIV=4, BLANK_CYC=1.
- **Scan order:** reset, load data=32'h0123_ABCD, dp=0.
  - which steps 0..7 every 4 cycles.
  - Each slot shows 1 cycle of 8'hFF, then 3 cycles of the glyph.
  - Digit 0 → 8'h03; digit 4 → 8'h11; digit 7 → 8'h85.
- **Suppression, nonzero value:** blank_lz=1, data=32'h0000_0050.
  - Digits 0..5 → 8'hFF.
  - Digit 6 → 8'h49; digit 7 → 8'h03.
- **Suppression, zero value:** blank_lz=1, data=0, dp=8'h80.
  - Digits 0..6 → 8'hFF.
  - Digit 7 → 8'h02.
- **Load mid-slot:** during a digit-3 glyph phase, load data=32'hFFFF_FFFF.
  - code=8'h71 on the next edge.
  - Un-strobed data changes have no effect.
- **Reset mid-scan:** assert rst while which=5.
  - which=0 and code=8'hFF before the next edge.
  - After release, the shadow reads 0 and digit 7 shows 8'h03.
- **Blink (SEG_BLINK_EN, BLINK_FRAMES=2):** blink=8'h01.
  - Digit 0 is 8'hFF during frames 2–3 and normal during frames 0–1.
  - All other digits are unaffected.
